bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Multi-digit BCD down counter (countdown timer) built with the same packed-BCD digit conventions as the existing BCD up counter; it counts in the opposite direction.
- Loads a decimal preset, counts down once per enabled clock and flags terminal count.
- Optionally reloads the preset automatically for periodic ticks.
- Sits beside the up counter in timer and display paths, driving the same 4-bit-per-digit BCD bus.

Parameters:
- DIGITS, 2, number of BCD digits; counter width is 4*DIGITS bits, digit 0 in bits [3:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_asyn  input  1  asynchronous, active-low reset; 0 resets immediately, release synchronous to clk.
- load  input  1  load preset from load_val.
- load_val  input  4*DIGITS  packed BCD preset.
- start  input  1  begin counting from current Q_out.
- stop  input  1  abort counting, hold value.
- pause  input  1  freeze count while running.
- auto_reload  input  1  reload preset at terminal count instead of stopping.
- Q_out  output  4*DIGITS  current packed BCD count.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at terminal count.
- load_err  output  1  sticky flag: last load attempt had a non-BCD digit.

Behaviour:
- Reset (rst_asyn=0, asynchronous):
  - Q_out=0, preset register=0, state=IDLE.
  - busy=0, done=0, load_err=0.
- States: IDLE, RUN. busy is registered and equals (state==RUN).
- Per-edge priority: load > stop > start > count.
- Load, accepted in any state:
  - Valid (every digit of load_val <= 9): Q_out and preset <= load_val; state <= IDLE; load_err <= 0.
  - Invalid (any digit 10..15): Q_out, preset and state unchanged; load_err <= 1. load_err stays 1 until the next valid load or reset.
- stop in RUN (no load): state <= IDLE, Q_out held, done=0. stop in IDLE is a no-op.
- start in IDLE:
  - Q_out != 0: state <= RUN; no decrement on that edge.
  - Q_out == 0: ignored, stays IDLE, no done.
  - start in RUN is ignored.
- RUN with pause=1: Q_out held, done=0.
- RUN with pause=0, decrement on every edge:
  - Digit 0 decrements by 1.
  - Any digit at 0 that must decrement becomes 9 and borrows from the next higher digit.
  - Digits never take values 10..15.
- Terminal count, on the RUN decrement edge where Q_out==1:
  - auto_reload=0: Q_out <= 0, state <= IDLE, done <= 1 for exactly one cycle.
  - auto_reload=1: Q_out <= preset, stay in RUN, done <= 1 for one cycle. Period is N cycles for preset N.
  - auto_reload is sampled only at the terminal edge.
- done is 0 on all other cycles, including after stop, load or reset.
- Latency: start sampled at edge 0 gives decrements at edges 1..N. Q_out reaches 0 (or reloads) at edge N, and done is high in the cycle after edge N.
- Reset mid-RUN: immediate return to reset values. The preset is lost.
- Load mid-RUN: the new value is taken and the block returns to IDLE; a restart needs start.

Test Plan:
- Reset then load_val=8'h12, start, pause=0 → Q_out 12,11,10,09,...,01,00 over 12 edges, then IDLE. Single done pulse after the 00 edge; busy=1 for exactly 12 cycles.
- Borrow chain, DIGITS=3: load 12'h100, start → next values 099 then 098, with no hex values ever appearing.
- auto_reload=1, load 8'h03, start, run 10 cycles → Q_out 02,01,03,02,01,03,...; done pulses every 3 cycles and busy stays 1.
- Invalid load 8'h1A: Q_out and preset unchanged, load_err=1. Then load 8'h05: Q_out=05, load_err=0. start with Q_out=00 → no RUN, no done.
- Hold controls, load 8'h20 and start: pause for 4 cycles mid-count freezes Q_out and done stays 0. stop at Q_out=15 gives IDLE with Q_out=15. A new start resumes 14,13,...
- Async reset: drop rst_asyn between clock edges while RUN at Q_out=07 → Q_out=00, busy=0 immediately. Load and start together on one edge → load wins, state IDLE.

Source files
------------

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit packed-BCD countdown timer with optional auto-reload and terminal-count pulse.
// Latency: one decrement per enabled edge after start; done is registered (cycle after terminal edge); no backpressure.
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_asyn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                auto_reload,
    output logic [4*DIGITS-1:0] Q_out,
    output logic                busy,
    output logic                done,
    output logic                load_err
);
    localparam int W = 4 * DIGITS;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state;
    logic [0:0]   state_nxt;
    logic [W-1:0] preset;
    logic [W-1:0] preset_nxt;
    logic [W-1:0] q_nxt;
    logic [W-1:0] dec_val;
    logic         done_nxt;
    logic         err_nxt;
    logic         load_ok;
    logic         borrow;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Ripple borrow: a zero digit wraps to 9 and keeps borrowing upward.
    always_comb begin
        dec_val = Q_out;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (Q_out[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = Q_out[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        q_nxt      = Q_out;
        preset_nxt = preset;
        state_nxt  = state;
        done_nxt   = 1'b0;
        err_nxt    = load_err;
        if (load) begin
            if (load_ok) begin
                q_nxt      = load_val;
                preset_nxt = load_val;
                state_nxt  = IDLE;
                err_nxt    = 1'b0;
            end else begin
                err_nxt    = 1'b1;
            end
        end else if (stop) begin
            state_nxt = IDLE;
        end else if (start && state == IDLE) begin
            if (Q_out != '0) begin
                state_nxt = RUN;
            end
        end else if (state == RUN && !pause) begin
            if (Q_out == W'(1)) begin
                done_nxt = 1'b1;
                if (auto_reload) begin
                    q_nxt = preset;
                end else begin
                    q_nxt     = '0;
                    state_nxt = IDLE;
                end
            end else begin
                q_nxt = dec_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_asyn) begin
        if (!rst_asyn) begin
            Q_out    <= '0;
            preset   <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            Q_out    <= q_nxt;
            preset   <= preset_nxt;
            state    <= state_nxt;
            busy     <= (state_nxt == RUN);
            done     <= done_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboarded bench for bcd_down_counter using an integer-arithmetic reference model.
module tb_bcd_down_counter;
    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_asyn;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] Q_out;
    logic         busy;
    logic         done;
    logic         load_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb[$];

    int m_cnt    = 0;
    int m_preset = 0;
    bit m_run    = 1'b0;
    bit m_done   = 1'b0;
    bit m_err    = 1'b0;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst_asyn   (rst_asyn),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .auto_reload(auto_reload),
        .Q_out      (Q_out),
        .busy       (busy),
        .done       (done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int bcd_value(input logic [W-1:0] v);
        int r     = 0;
        int scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) return -1;
            r     += d * scale;
            scale *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r = '0;
        int p = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(p % 10);
            p           = p / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_done = 1'b0;
        if (!rst_asyn) begin
            m_cnt = 0; m_preset = 0; m_run = 1'b0; m_err = 1'b0;
        end else if (load) begin
            int v = bcd_value(load_val);
            if (v >= 0) begin
                m_cnt = v; m_preset = v; m_run = 1'b0; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (stop) begin
            m_run = 1'b0;
        end else if (start && !m_run) begin
            if (m_cnt != 0) m_run = 1'b1;
        end else if (m_run && !pause) begin
            if (m_cnt == 1) begin
                m_done = 1'b1;
                if (auto_reload) begin
                    m_cnt = m_preset;
                end else begin
                    m_cnt = 0;
                    m_run = 1'b0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic cycle(input logic ld, input logic [W-1:0] lv, input logic st,
                         input logic sp, input logic ps, input logic ar);
        load = ld; load_val = lv; start = st; stop = sp; pause = ps; auto_reload = ar;
        @(posedge clk);
        model_edge();
        sb.push_back('{to_bcd(m_cnt), m_run, m_done, m_err});
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic ar);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, ar);
    endtask

    task automatic run_until(input int target, input string name);
        int guard = 0;
        while (m_cnt != target && guard < 100) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check({name, "_reached"}, W'(m_cnt), W'(target));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("q_out", Q_out, e.q);
            check("busy", W'(busy), W'(e.busy));
            check("done", W'(done), W'(e.done));
            check("load_err", W'(load_err), W'(e.err));
        end
    end

    initial begin
        rst_asyn = 1'b0; load = 1'b0; load_val = '0; start = 1'b0;
        stop = 1'b0; pause = 1'b0; auto_reload = 1'b0;
        #12;
        check("rst_q", Q_out, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_err", W'(load_err), '0);
        @(negedge clk);
        rst_asyn = 1'b1;

        // 12 down to 0, then idle
        cycle(1'b1, 12'h012, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(15, 1'b0);

        // borrow chain across two digits
        cycle(1'b1, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

        // periodic reload
        cycle(1'b1, 12'h003, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycles(10, 1'b1);
        idle_cycles(4, 1'b0);

        // invalid load, valid load, start from zero
        cycle(1'b1, 12'h01A, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        cycle(1'b1, 12'h005, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);

        // pause, stop at 15, resume
        cycle(1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_until(15, "stop_point");
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);

        // asynchronous reset mid-run at 7
        cycle(1'b1, 12'h009, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until(7, "reset_point");
        @(negedge clk);
        #2;
        rst_asyn = 1'b0;
        #1;
        check("async_q", Q_out, '0);
        check("async_busy", W'(busy), '0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_asyn = 1'b1;
        idle_cycles(1, 1'b0);

        // load and start on the same edge
        cycle(1'b1, 12'h042, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic         ld;
            logic [W-1:0] lv;
            ld = ($urandom % 16) == 0;
            if (($urandom % 4) != 0) lv = to_bcd(int'($urandom % 1000));
            else lv = W'($urandom);
            cycle(ld, lv, ($urandom % 4) == 0, ($urandom % 32) == 0,
                  ($urandom % 8) == 0, 1'($urandom));
        end

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
